jtag_tap_controller: RTL

- IEEE 1149.1 TAP controller that sequences the boundary-scan register (BSR) chain of BC_1 cells.
- Contains the 16-state TAP FSM, instruction register, bypass register and optional IDCODE register.
- Generates the chain controls clk_dr, shift_dr, update_dr, mode and bsr_reset, and muxes TDO.
- Sits between the JTAG pins and the BSR chain; tdi feeds the first cell and the last cell's serial output returns on bsr_tdo.

---
 rtl/jtag_pkg.sv | 32 +++
 rtl/jtag_tap_fsm.sv | 43 ++++
 rtl/jtag_tap_controller.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/jtag_pkg.sv
// Shared TAP definitions: 1149.1 state encoding, opcode constants and the IR capture pattern.
package jtag_pkg;

  typedef enum logic [3:0] {
    TAP_EX2DR   = 4'h0,
    TAP_EX1DR   = 4'h1,
    TAP_SHDR    = 4'h2,
    TAP_PAUSEDR = 4'h3,
    TAP_SELIR   = 4'h4,
    TAP_UPDDR   = 4'h5,
    TAP_CAPDR   = 4'h6,
    TAP_SELDR   = 4'h7,
    TAP_EX2IR   = 4'h8,
    TAP_EX1IR   = 4'h9,
    TAP_SHIR    = 4'hA,
    TAP_PAUSEIR = 4'hB,
    TAP_RTI     = 4'hC,
    TAP_UPDIR   = 4'hD,
    TAP_CAPIR   = 4'hE,
    TAP_TLR     = 4'hF
  } tap_state_t;

  localparam int unsigned IDCODE_WIDTH = 32;

  // Opcodes are truncated to IR_WIDTH at the point of use; BYPASS stays all ones.
  localparam logic [31:0] OP_EXTEST  = 32'h0000_0000;
  localparam logic [31:0] OP_SAMPLE  = 32'h0000_0001;
  localparam logic [31:0] OP_IDCODE  = 32'h0000_0002;
  localparam logic [31:0] OP_BYPASS  = 32'hFFFF_FFFF;
  localparam logic [31:0] IR_CAPTURE = 32'h0000_0001;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller state machine, advanced by tms on rising tck.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       reset,
  input  logic       tms,
  output tap_state_t state
);

  tap_state_t state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      TAP_TLR:     state_d = tms ? TAP_TLR     : TAP_RTI;
      TAP_RTI:     state_d = tms ? TAP_SELDR   : TAP_RTI;
      TAP_SELDR:   state_d = tms ? TAP_SELIR   : TAP_CAPDR;
      TAP_CAPDR:   state_d = tms ? TAP_EX1DR   : TAP_SHDR;
      TAP_SHDR:    state_d = tms ? TAP_EX1DR   : TAP_SHDR;
      TAP_EX1DR:   state_d = tms ? TAP_UPDDR   : TAP_PAUSEDR;
      TAP_PAUSEDR: state_d = tms ? TAP_EX2DR   : TAP_PAUSEDR;
      TAP_EX2DR:   state_d = tms ? TAP_UPDDR   : TAP_SHDR;
      TAP_UPDDR:   state_d = tms ? TAP_SELDR   : TAP_RTI;
      TAP_SELIR:   state_d = tms ? TAP_TLR     : TAP_CAPIR;
      TAP_CAPIR:   state_d = tms ? TAP_EX1IR   : TAP_SHIR;
      TAP_SHIR:    state_d = tms ? TAP_EX1IR   : TAP_SHIR;
      TAP_EX1IR:   state_d = tms ? TAP_UPDIR   : TAP_PAUSEIR;
      TAP_PAUSEIR: state_d = tms ? TAP_EX2IR   : TAP_PAUSEIR;
      TAP_EX2IR:   state_d = tms ? TAP_UPDIR   : TAP_SHIR;
      TAP_UPDIR:   state_d = tms ? TAP_SELDR   : TAP_RTI;
      default:     state_d = TAP_TLR;
    endcase
  end

  always_ff @(posedge tck or negedge reset) begin
    if (!reset) state_q <= TAP_TLR;
    else        state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1 TAP controller driving a BC_1 boundary-scan chain.
// Optional IDCODE register enabled by defining JTAG_IDCODE_EN.
module jtag_tap_controller
  import jtag_pkg::*;
#(
  parameter int unsigned IR_WIDTH     = 4,
  parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
  input  logic                tck,
  input  logic                reset,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_en,
  input  logic                bsr_tdo,
  output logic                bsr_tdi,
  output logic                clk_dr,
  output logic                shift_dr,
  output logic                update_dr,
  output logic                mode,
  output logic                bsr_reset,
  output logic [IR_WIDTH-1:0] instruction
);

  localparam logic [IR_WIDTH-1:0] IR_EXTEST = IR_WIDTH'(OP_EXTEST);
  localparam logic [IR_WIDTH-1:0] IR_SAMPLE = IR_WIDTH'(OP_SAMPLE);
  localparam logic [IR_WIDTH-1:0] IR_BYPASS = IR_WIDTH'(OP_BYPASS);
`ifdef JTAG_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(OP_IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_RESET  = IR_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] IR_RESET  = IR_BYPASS;
`endif

  if (IR_WIDTH < 2 || IDCODE_VALUE[0] != 1'b1) begin : g_bad_param
    $error("jtag_tap_controller: IR_WIDTH must be >= 2 and IDCODE_VALUE[0] must be 1");
  end

  // Unsupported opcodes collapse to BYPASS so downstream selection only sees legal values.
  function automatic logic [IR_WIDTH-1:0] decode_ir(input logic [IR_WIDTH-1:0] op);
    logic [IR_WIDTH-1:0] dec;
    dec = IR_BYPASS;
    if (op == IR_EXTEST || op == IR_SAMPLE) dec = op;
`ifdef JTAG_IDCODE_EN
    if (op == IR_IDCODE) dec = op;
`endif
    return dec;
  endfunction

  tap_state_t state;

  jtag_tap_fsm u_fsm (
    .tck   (tck),
    .reset (reset),
    .tms   (tms),
    .state (state)
  );

  logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic                bypass_q, bypass_d;
  logic                tdo_q, tdo_d, tdo_en_q, tdo_en_d;
  logic                clk_dr_en_q, clk_dr_en_d;
  logic                shift_dr_q, shift_dr_d;
  logic                update_dr_q, update_dr_d;
  logic                mode_q, mode_d;
  logic                bsr_sel, idcode_sel, dr_lsb;

  assign bsr_sel = (ir_q == IR_EXTEST) || (ir_q == IR_SAMPLE);

`ifdef JTAG_IDCODE_EN
  logic [IDCODE_WIDTH-1:0] idcode_q, idcode_d;

  assign idcode_sel = (ir_q == IR_IDCODE);

  always_comb begin
    idcode_d = idcode_q;
    if (idcode_sel && state == TAP_CAPDR)     idcode_d = IDCODE_VALUE;
    else if (idcode_sel && state == TAP_SHDR) idcode_d = {tdi, idcode_q[IDCODE_WIDTH-1:1]};
  end

  always_ff @(posedge tck or negedge reset) begin
    if (!reset) idcode_q <= '0;
    else        idcode_q <= idcode_d;
  end
`else
  assign idcode_sel = 1'b0;
`endif

  always_comb begin
    dr_lsb = bsr_sel ? bsr_tdo : bypass_q;
`ifdef JTAG_IDCODE_EN
    if (idcode_sel) dr_lsb = idcode_q[0];
`endif
  end

  // Shift stages advance on rising tck.
  always_comb begin
    ir_shift_d = ir_shift_q;
    bypass_d   = bypass_q;
    if (state == TAP_CAPIR)     ir_shift_d = IR_WIDTH'(IR_CAPTURE);
    else if (state == TAP_SHIR) ir_shift_d = {tdi, ir_shift_q[IR_WIDTH-1:1]};
    if (!bsr_sel && !idcode_sel) begin
      if (state == TAP_CAPDR)     bypass_d = 1'b0;
      else if (state == TAP_SHDR) bypass_d = tdi;
    end
  end

  always_ff @(posedge tck or negedge reset) begin
    if (!reset) begin
      ir_shift_q <= '0;
      bypass_q   <= 1'b0;
    end else begin
      ir_shift_q <= ir_shift_d;
      bypass_q   <= bypass_d;
    end
  end

  // Falling-tck controls: outputs settle half a cycle before the next capturing edge.
  always_comb begin
    ir_d = ir_q;
    if (state == TAP_TLR)        ir_d = IR_RESET;
    else if (state == TAP_UPDIR) ir_d = decode_ir(ir_shift_q);
    tdo_d    = 1'b0;
    tdo_en_d = 1'b0;
    if (state == TAP_SHIR) begin
      tdo_d    = ir_shift_q[0];
      tdo_en_d = 1'b1;
    end else if (state == TAP_SHDR) begin
      tdo_d    = dr_lsb;
      tdo_en_d = 1'b1;
    end
    clk_dr_en_d = (state == TAP_CAPDR || state == TAP_SHDR) && bsr_sel;
    shift_dr_d  = (state == TAP_SHDR);
    update_dr_d = (state == TAP_UPDDR) && bsr_sel;
    mode_d      = (ir_d == IR_EXTEST);
  end

  always_ff @(negedge tck or negedge reset) begin
    if (!reset) begin
      ir_q        <= IR_RESET;
      tdo_q       <= 1'b0;
      tdo_en_q    <= 1'b0;
      clk_dr_en_q <= 1'b0;
      shift_dr_q  <= 1'b0;
      update_dr_q <= 1'b0;
      mode_q      <= 1'b0;
    end else begin
      ir_q        <= ir_d;
      tdo_q       <= tdo_d;
      tdo_en_q    <= tdo_en_d;
      clk_dr_en_q <= clk_dr_en_d;
      shift_dr_q  <= shift_dr_d;
      update_dr_q <= update_dr_d;
      mode_q      <= mode_d;
    end
  end

  // Enable only changes while tck is low, so the gated clock cannot glitch.
  assign clk_dr      = ~(tck & clk_dr_en_q);
  assign tdo         = tdo_q;
  assign tdo_en      = tdo_en_q;
  assign shift_dr    = shift_dr_q;
  assign update_dr   = update_dr_q;
  assign mode        = mode_q;
  assign instruction = ir_q;
  assign bsr_tdi     = tdi;
  assign bsr_reset   = reset & (state != TAP_TLR);

endmodule
